// File: rtl/maxpool_tile_scheduler.sv
// -----------------------------------------------------------------------------
// maxpool_tile_scheduler
//
// Walks a square feature map of mat_size x mat_size pixels in SA_N x SA_N
// tiles, raster order (row-major, tile bases stepping by SA_N). For each tile
// it requests the upstream array to produce the tile, waits until the tile has
// been fed to the maxpool unit, then waits for the maxpool unit to emit all
// E = (SA_N/FILTER_H)*(SA_N/FILTER_W) pooled outputs and go idle before moving
// on to the next tile.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   start, mat_size   : one-cycle map request and its edge length (IDLE only)
//   busy, done, err   : status; done is a one-cycle pulse, err is sticky
//   tile_req_valid/_ready, tile_req_row/_col : tile request to upstream array
//   tile_fed          : upstream pulse, current tile fully presented
//   pos_row, pos_col  : tile base presented to the maxpool unit
//   mp_out_valid, mp_idle : maxpool output strobe and idle indicator
//   pooled_count      : pooled outputs seen since the last accepted start
//   state_dbg         : current FSM state, for observation only
//
// Handshake: a tile request transfers in the cycle where tile_req_valid and
// tile_req_ready are both high. Once valid is raised it stays high, and
// tile_req_row/col stay unchanged, until that transfer; ready may toggle
// freely and has no effect while valid is low.
// -----------------------------------------------------------------------------
module maxpool_tile_scheduler #(
  parameter int SA_N     = 4,
  parameter int MAX_N    = 64,
  parameter int N_BITS   = $clog2(MAX_N),
  parameter int FILTER_H = 2,
  parameter int FILTER_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_BITS:0]       mat_size,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  tile_req_valid,
  input  logic                  tile_req_ready,
  output logic [N_BITS-1:0]     tile_req_row,
  output logic [N_BITS-1:0]     tile_req_col,
  input  logic                  tile_fed,
  output logic [N_BITS-1:0]     pos_row,
  output logic [N_BITS-1:0]     pos_col,
  input  logic                  mp_out_valid,
  input  logic                  mp_idle,
  output logic [2*N_BITS-1:0]   pooled_count,
  output logic [2:0]            state_dbg
);

  localparam int E  = (SA_N / FILTER_H) * (SA_N / FILTER_W);
  // One spare bit above E so an over-count is representable; saturates.
  localparam int CW = $clog2(E + 1) + 1;

  localparam logic [N_BITS:0] SA_W  = (N_BITS + 1)'(SA_N);
  localparam logic [N_BITS:0] MAX_W = (N_BITS + 1)'(MAX_N);
  localparam logic [CW-1:0]   E_W   = CW'(E);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [N_BITS:0]       size_q, size_d;
  logic [N_BITS:0]       row_q, row_d;
  logic [N_BITS:0]       col_q, col_d;
  logic [CW-1:0]         tile_cnt_q, tile_cnt_d;
  logic [2*N_BITS-1:0]   pooled_q, pooled_d;
  logic                  err_q, err_d;

  logic                  size_legal;
  logic                  in_tile;
  logic                  strobe_in_tile;
  logic                  strobe_stray;
  logic [CW-1:0]         cnt_now;
  logic                  last_col;
  logic                  last_row;

  assign size_legal = (mat_size != '0) && (mat_size <= MAX_W) &&
                      ((mat_size % SA_W) == '0);

  assign in_tile        = (state_q == S_ISSUE) || (state_q == S_FEED) ||
                          (state_q == S_DRAIN);
  assign strobe_in_tile = mp_out_valid && in_tile;
  assign strobe_stray   = mp_out_valid && !in_tile;

  // Per-tile count including a strobe arriving this cycle.
  assign cnt_now = !strobe_in_tile    ? tile_cnt_q :
                   (tile_cnt_q == '1) ? tile_cnt_q :
                                        tile_cnt_q + CW'(1);

  // Unsigned at N_BITS+1 so col+SA_N == mat_size cannot wrap at MAX_N.
  assign last_col = (col_q + SA_W) == size_q;
  assign last_row = (row_q + SA_W) == size_q;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    row_d      = row_q;
    col_d      = col_q;
    tile_cnt_d = cnt_now;
    pooled_d   = pooled_q;
    err_d      = err_q;

    if (mp_out_valid && (state_q != S_IDLE)) begin
      pooled_d = pooled_q + (2 * N_BITS)'(1);
    end

    // Any strobe outside a tile, or one beyond E inside a tile, is an error;
    // counting carries on regardless.
    if (strobe_stray || (strobe_in_tile && (tile_cnt_q >= E_W))) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (size_legal) begin
            size_d     = mat_size;
            row_d      = '0;
            col_d      = '0;
            tile_cnt_d = '0;
            pooled_d   = '0;
            err_d      = 1'b0;
            state_d    = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (tile_req_ready) state_d = S_FEED;
      end
      S_FEED: begin
        if (tile_fed) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // >= rather than == so an over-counted tile (already flagged in err)
        // still drains instead of hanging the map.
        if ((cnt_now >= E_W) && mp_idle) state_d = S_NEXT;
      end
      S_NEXT: begin
        tile_cnt_d = '0;
        if (last_col && last_row) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          if (last_col) begin
            col_d = '0;
            row_d = row_q + SA_W;
          end else begin
            col_d = col_q + SA_W;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      tile_cnt_q <= '0;
      pooled_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tile_cnt_q <= tile_cnt_d;
      pooled_q   <= pooled_d;
      err_q      <= err_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign tile_req_valid = (state_q == S_ISSUE);
  assign tile_req_row   = row_q[N_BITS-1:0];
  assign tile_req_col   = col_q[N_BITS-1:0];
  assign pos_row        = row_q[N_BITS-1:0];
  assign pos_col        = col_q[N_BITS-1:0];
  assign pooled_count   = pooled_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_maxpool_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_maxpool_tile_scheduler
//
// Plays the upstream array and the maxpool unit around the scheduler. The
// expected tile sequence for a map is generated by plain nested loops over the
// map and queued in exp_q; the expected pooled count and error flag follow
// from the number of strobes the bench sends per tile.
// -----------------------------------------------------------------------------
module tb_maxpool_tile_scheduler;

  localparam int SA_N   = 4;
  localparam int MAX_N  = 64;
  localparam int N_BITS = 6;
  localparam int E      = 4;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [N_BITS:0]      mat_size;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 tile_req_valid;
  logic                 tile_req_ready;
  logic [N_BITS-1:0]    tile_req_row;
  logic [N_BITS-1:0]    tile_req_col;
  logic                 tile_fed;
  logic [N_BITS-1:0]    pos_row;
  logic [N_BITS-1:0]    pos_col;
  logic                 mp_out_valid;
  logic                 mp_idle;
  logic [2*N_BITS-1:0]  pooled_count;
  logic [2:0]           state_dbg;

  maxpool_tile_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mat_size       (mat_size),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .tile_req_valid (tile_req_valid),
    .tile_req_ready (tile_req_ready),
    .tile_req_row   (tile_req_row),
    .tile_req_col   (tile_req_col),
    .tile_fed       (tile_fed),
    .pos_row        (pos_row),
    .pos_col        (pos_col),
    .mp_out_valid   (mp_out_valid),
    .mp_idle        (mp_idle),
    .pooled_count   (pooled_count),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [2*N_BITS-1:0] exp_q[$];   // {row, col} of each expected tile
  int                  exp_pooled;
  logic                exp_err;
  int                  tile_strobes;
  int                  n_checks;
  int                  n_errors;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic plan_map(input int ms);
    for (int r = 0; r < ms; r += SA_N)
      for (int c = 0; c < ms; c += SA_N)
        exp_q.push_back({N_BITS'(r), N_BITS'(c)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_strobe();
    mp_out_valid = 1'b1;
    @(negedge clk);
    mp_out_valid = 1'b0;
    tile_strobes++;
    exp_pooled++;
    if (tile_strobes > E) exp_err = 1'b1;
    check("err_after_strobe", err, exp_err);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  // Waits for the request, checks its coordinates, handshakes after a random
  // stall. Returns with the DUT in FEED and mp_idle low.
  task automatic accept_tile(output logic [2*N_BITS-1:0] rc);
    int waited;
    int rd;
    waited = 0;
    while (!tile_req_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_valid_wait", tile_req_valid, 1);
    check("exp_q_nonempty", exp_q.size() != 0, 1);
    rc = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("req_row", tile_req_row, rc[2*N_BITS-1:N_BITS]);
    check("req_col", tile_req_col, rc[N_BITS-1:0]);
    check("pos_row", pos_row, rc[2*N_BITS-1:N_BITS]);
    check("pos_col", pos_col, rc[N_BITS-1:0]);
    rd = $urandom_range(0, 3);
    tile_req_ready = 1'b0;
    repeat (rd) begin
      @(negedge clk);
      check("req_valid_hold", tile_req_valid, 1);
      check("req_row_hold", tile_req_row, rc[2*N_BITS-1:N_BITS]);
      check("req_col_hold", tile_req_col, rc[N_BITS-1:0]);
    end
    tile_req_ready = 1'b1;
    @(negedge clk);
    tile_req_ready = 1'b0;
    mp_idle = 1'b0;
    tile_strobes = 0;
    check("req_valid_drop", tile_req_valid, 0);
  endtask

  task automatic do_tile(input int n_str, input bit last, input bit feed_all);
    logic [2*N_BITS-1:0] rc;
    int a;
    accept_tile(rc);
    a = feed_all ? n_str : int'($urandom_range(0, n_str));
    for (int i = 0; i < a; i++) send_strobe();
    tile_fed = 1'b1;
    start    = 1'b1;          // must be ignored outside IDLE
    mat_size = 7'd4;
    @(negedge clk);
    tile_fed = 1'b0;
    start    = 1'b0;
    for (int i = a; i < n_str; i++) send_strobe();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("drain_hold_busy", busy, 1);
      check("drain_hold_valid", tile_req_valid, 0);
      check("drain_pos_row", pos_row, rc[2*N_BITS-1:N_BITS]);
      check("drain_pos_col", pos_col, rc[N_BITS-1:0]);
    end
    mp_idle = 1'b1;
    @(negedge clk);   // first cycle after drain exit
    check("next_valid", tile_req_valid, 0);
    check("next_done", done, 0);
    @(negedge clk);   // second cycle: request again, or done
    if (last) begin
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_valid", tile_req_valid, 0);
      @(negedge clk);
      check("done_clear", done, 0);
      check("busy_after_done", busy, 0);
    end else begin
      check("next_req_valid", tile_req_valid, 1);
    end
    check("pooled_count", pooled_count, exp_pooled);
    check("err_tile_end", err, exp_err);
  endtask

  task automatic do_start(input int ms);
    start    = 1'b1;
    mat_size = 7'(ms);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_map(input int ms, input int extra_idx);
    int nt;
    plan_map(ms);
    nt = (ms / SA_N) * (ms / SA_N);
    do_start(ms);
    exp_pooled = 0;
    exp_err    = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clr", err, 0);
    check("start_pooled_clr", pooled_count, 0);
    for (int t = 0; t < nt; t++)
      do_tile((t == extra_idx) ? E + 1 : E, t == nt - 1, t == extra_idx);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic bad_start(input int ms);
    do_start(ms);
    exp_err = 1'b1;
    check("bad_err", err, exp_err);
    check("bad_busy", busy, 0);
    check("bad_valid", tile_req_valid, 0);
    @(negedge clk);
    check("bad_err_sticky", err, exp_err);
    check("bad_busy2", busy, 0);
    check("bad_valid2", tile_req_valid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_valid"}, tile_req_valid, 0);
    check({tag, "_row"}, tile_req_row, 0);
    check({tag, "_col"}, tile_req_col, 0);
    check({tag, "_pos_row"}, pos_row, 0);
    check({tag, "_pos_col"}, pos_col, 0);
    check({tag, "_pooled"}, pooled_count, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2*N_BITS-1:0] rc;
    int ms;
    int nt;
    n_checks       = 0;
    n_errors       = 0;
    exp_pooled     = 0;
    exp_err        = 1'b0;
    tile_strobes   = 0;
    reset          = 1'b1;
    start          = 1'b0;
    mat_size       = '0;
    tile_req_ready = 1'b0;
    tile_fed       = 1'b0;
    mp_out_valid   = 1'b0;
    mp_idle        = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clk);

    // Reference 8x8 map: four tiles in raster order, 16 outputs.
    run_map(8, -1);

    // Illegal sizes: not a multiple, zero, above MAX_N.
    bad_start(6);
    bad_start(0);
    bad_start(68);

    // Legal start clears the sticky error.
    run_map(4, -1);

    // Stray strobe while idle sets err without counting.
    mp_out_valid = 1'b1;
    @(negedge clk);
    mp_out_valid = 1'b0;
    check("stray_idle_err", err, 1);
    check("stray_idle_pooled", pooled_count, exp_pooled);

    // Over-count in the third tile: err rises, map still completes.
    run_map(8, 2);

    // Largest map, exercises the top coordinate 60.
    run_map(MAX_N, -1);

    // Random maps, random over-count tile.
    for (int k = 0; k < 4; k++) begin
      ms = SA_N * int'($urandom_range(1, 4));
      nt = (ms / SA_N) * (ms / SA_N);
      run_map(ms, int'($urandom_range(0, nt)) - 1);
    end

    // Reset during the drain of tile (0,4) of an 8x8 map.
    plan_map(8);
    do_start(8);
    exp_pooled = 0;
    exp_err    = 1'b0;
    do_tile(E, 1'b0, 1'b0);
    accept_tile(rc);
    tile_fed = 1'b1;
    @(negedge clk);
    tile_fed = 1'b0;
    send_strobe();
    send_strobe();
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    exp_q.delete();
    @(negedge clk);
    check("rst_hold_done", done, 0);
    reset   = 1'b0;
    mp_idle = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    run_map(4, -1);
    check("post_rst_pooled", pooled_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a sequence wedges despite the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maxpool_tile_scheduler.md
MAXPOOL_TILE_SCHEDULER -- requirements
Module: maxpool_tile_scheduler

Interface
REQ-001 Parameter SA_N, default 4, tile edge in pixels; equals maxpool scratch dimension.
REQ-002 Parameter MAX_N, default 64, maximum feature-map dimension.
REQ-003 Parameter N_BITS, default $clog2(MAX_N), coordinate width.
REQ-004 Parameters FILTER_H and FILTER_W, default 2 each, pooling window height and width.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to pool a full feature map.
REQ-008 mat_size  in  N_BITS+1  feature-map edge (square map), sampled on accepted start.
REQ-009 busy  out  1  high from accepted start until the done pulse, inclusive.
REQ-010 done  out  1  one-cycle pulse when the last tile has fully drained.
REQ-011 err  out  1  sticky error flag; cleared only by reset or accepted start.
REQ-012 tile_req_valid / tile_req_ready  out / in  1 / 1  valid/ready handshake requesting the upstream array to produce one tile.
REQ-013 tile_req_row, tile_req_col  out  N_BITS each  tile base coordinates; stable while tile_req_valid && !tile_req_ready.
REQ-014 tile_fed  in  1  upstream one-cycle pulse: all SA_N*SA_N samples of the current tile have been presented to the maxpool unit.
REQ-015 pos_row, pos_col  out  N_BITS each  tile base driven to the maxpool unit; equal to tile_req_row/tile_req_col.
REQ-016 mp_out_valid  in  1  maxpool output strobe.
REQ-017 mp_idle  in  1  maxpool idle indicator.
REQ-018 pooled_count  out  2*N_BITS  pooled outputs observed since the last accepted start.

Function
REQ-019 FSM states: IDLE, ISSUE, FEED, DRAIN, NEXT, DONE; registered state, one transition per cycle at most.
REQ-020 IDLE: start with mat_size nonzero, a multiple of SA_N, and <= MAX_N is accepted: latch mat_size, tile_row=tile_col=0, clear per-tile count, pooled_count and err, go to ISSUE.
REQ-021 IDLE: start with an illegal mat_size sets err next cycle; FSM stays in IDLE; busy stays low.
REQ-022 start in any state other than IDLE is ignored.
REQ-023 ISSUE: tile_req_valid=1; on tile_req_valid && tile_req_ready go to FEED next cycle.
REQ-024 FEED: wait for tile_fed, then go to DRAIN; tile_fed in any other state is ignored.
REQ-025 Per-tile expected outputs: E = (SA_N/FILTER_H)*(SA_N/FILTER_W); 4 at defaults.
REQ-026 Per-tile count increments on every mp_out_valid in ISSUE, FEED or DRAIN.
REQ-027 pooled_count increments on every mp_out_valid while busy.
REQ-028 DRAIN: when the per-tile count (including a strobe in the same cycle) equals E and mp_idle=1, go to NEXT.
REQ-029 mp_out_valid that would push the per-tile count above E, or that arrives in IDLE, NEXT or DONE, sets err; counting continues.
REQ-030 NEXT: clear the per-tile count and advance raster order: tile_col += SA_N; when tile_col+SA_N == mat_size, set tile_col=0 and tile_row += SA_N.
REQ-031 NEXT: if the tile just finished was at (mat_size-SA_N, mat_size-SA_N), go to DONE instead of advancing; otherwise go to ISSUE.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE; busy drops in the cycle after done.
REQ-033 pos_row/pos_col update only in NEXT; they therefore stay constant from ISSUE through DRAIN of a tile.
REQ-034 Coordinate arithmetic is unsigned at N_BITS+1 width internally; comparisons against mat_size do not wrap.
REQ-035 Latency from DRAIN exit to the next tile_req_valid is exactly 2 cycles (NEXT, then ISSUE).

Reset
REQ-036 Asynchronous reset forces IDLE and drives busy=0, done=0, err=0, tile_req_valid=0, tile_req_row=tile_req_col=0, pos_row=pos_col=0, pooled_count=0.
REQ-037 Reset asserted mid-operation abandons the map; no done pulse is produced; after release the block accepts a new start.

Verification
REQ-038 mat_size=8, SA_N=4, ready tied high, 4 strobes per tile -> tiles (0,0),(0,4),(4,0),(4,4) in order, pooled_count=16, one done pulse, err=0.
REQ-039 start with mat_size=6 -> err=1 next cycle, busy=0, no tile_req_valid.
REQ-040 tile_req_ready held low 3 cycles in ISSUE -> tile_req_valid and tile_req_row/col stable for 3 cycles; handshake on the 4th cycle; FSM enters FEED.
REQ-041 5 mp_out_valid strobes in one tile -> err=1 at the 5th; sequencing continues; done still pulses.
REQ-042 mp_idle held low 2 cycles after the 4th strobe -> FSM stays in DRAIN until mp_idle=1, then NEXT.
REQ-043 Reset pulse during DRAIN of tile (0,4) -> all outputs at reset values; a subsequent start with mat_size=4 completes one tile at (0,0) with pooled_count=4.
